// File: rtl/hpi_responder.sv
// hpi_responder
//   Target side of the CY7C67200 HPI bus. It stands in for the EZ-OTG part
//   so the HPI driver and the game top can run without the real device.
//   It holds a word RAM reached through the ADDRESS/DATA registers, a
//   two-way mailbox with a local-side handshake, and a STATUS register.
//   OTG_INT tells the host that the outbound mailbox holds an unread word.
//
// Build option:
//   HPI_AUTOINC_EN  when defined, ADDRESS advances by 2 after every DATA
//                   read or write. When undefined, ADDRESS changes only on
//                   an ADDRESS write or a reset.
//
// Parameters:
//   MEM_WORDS  RAM depth in 16-bit words (power of two, 2..32768)
//   RD_LAT     cycles from the read start edge to OTG_DATA driven (1..4)
//
// Ports:
//   Clk, Reset        system clock and synchronous active-high reset
//   OTG_DATA          HPI data bus; driven only while a read is active
//   OTG_ADDR          register select: 0=DATA 1=MAILBOX 2=ADDRESS 3=STATUS
//   OTG_CS_N          chip select, active low
//   OTG_RD_N          read strobe, active low
//   OTG_WR_N          write strobe, active low
//   OTG_RST_N         HPI reset, active low
//   OTG_INT           interrupt to host, high while the outbound mailbox is full
//   mbx_in_valid      inbound mailbox word not yet consumed locally
//   mbx_in_data       last word the host wrote to MAILBOX
//   mbx_in_ack        local side consumes the inbound word
//   mbx_out_wr        local side posts mbx_out_data to the outbound mailbox
//   mbx_out_data      word posted by mbx_out_wr
//   mbx_out_full      outbound mailbox holds an unread word
module hpi_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int RD_LAT    = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  inout  wire  [15:0] OTG_DATA,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_RST_N,
  output logic        OTG_INT,
  output logic        mbx_in_valid,
  output logic [15:0] mbx_in_data,
  input  logic        mbx_in_ack,
  input  logic        mbx_out_wr,
  input  logic [15:0] mbx_out_data,
  output logic        mbx_out_full
);

  localparam int          AW        = (MEM_WORDS > 2) ? $clog2(MEM_WORDS) : 1;
  localparam logic [15:0] MEM_LIMIT = 16'(MEM_WORDS);
  localparam logic [2:0]  LAT_INIT  = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_MBX  = 2'd1,
    REG_ADDR = 2'd2,
    REG_STAT = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2
  } rd_state_e;

  logic [15:0] mem [MEM_WORDS];

  logic        cs_q, rd_q, wr_q;
  logic [15:0] address;
  logic        overflow;
  logic [15:0] out_data;
  rd_state_e   rd_state;
  reg_sel_e    rd_sel;
  logic [2:0]  lat_cnt;
  logic        oe;
  logic [15:0] dout;
  logic [15:0] ram_q;
  logic        ram_ok;
  logic [15:0] read_word;

  logic clr;
  logic in_range;
  logic rd_start, wr_start, rd_end, rd_fin;

  function automatic logic [15:0] status_word(input logic ovf, input logic in_v,
                                              input logic out_f);
    return {13'b0, ovf, in_v, out_f};
  endfunction

  // The host-side HPI reset clears the same state as the system reset.
  assign clr      = Reset | ~OTG_RST_N;
  assign in_range = ({1'b0, address[15:1]} < MEM_LIMIT);

  // Both strobes low together is an illegal sample and starts nothing.
  assign rd_start = ~OTG_CS_N & ~OTG_RD_N & OTG_WR_N & rd_q;
  assign wr_start = ~OTG_CS_N & ~OTG_WR_N & OTG_RD_N & wr_q;
  assign rd_end   = OTG_RD_N & ~rd_q & ~cs_q;
  // Post-actions only for a read that actually started and was not reset.
  assign rd_fin   = rd_end & (rd_state != RD_IDLE);

  assign OTG_DATA = oe ? dout : 16'hzzzz;

  always_comb begin
    read_word = 16'h0000;
    case (rd_sel)
      REG_DATA: read_word = ram_ok ? ram_q : 16'h0000;
      REG_MBX:  read_word = out_data;
      REG_ADDR: read_word = address;
      REG_STAT: read_word = status_word(overflow, mbx_in_valid, mbx_out_full);
      default:  read_word = 16'h0000;
    endcase
  end

  // Strobe sample stage: previous values for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cs_q <= 1'b1;
      rd_q <= 1'b1;
      wr_q <= 1'b1;
    end else begin
      cs_q <= OTG_CS_N;
      rd_q <= OTG_RD_N;
      wr_q <= OTG_WR_N;
    end
  end

  // RAM stage: write commits on the start edge; the read word is captured
  // on the start edge and presented once the read latency has elapsed.
  always_ff @(posedge Clk) begin
    if (!clr && wr_start && OTG_ADDR == REG_DATA && in_range)
      mem[address[AW:1]] <= OTG_DATA;
    if (rd_start) begin
      ram_q  <= mem[address[AW:1]];
      ram_ok <= in_range;
    end
  end

  // Register, mailbox and read-sequencer stage.
  always_ff @(posedge Clk) begin
    if (clr) begin
      address      <= 16'h0000;
      mbx_in_valid <= 1'b0;
      mbx_in_data  <= 16'h0000;
      overflow     <= 1'b0;
      out_data     <= 16'h0000;
      mbx_out_full <= 1'b0;
      OTG_INT      <= 1'b0;
      rd_state     <= RD_IDLE;
      rd_sel       <= REG_DATA;
      lat_cnt      <= 3'd0;
      oe           <= 1'b0;
      dout         <= 16'h0000;
    end else begin
      if (wr_start && OTG_ADDR == REG_ADDR)
        address <= {OTG_DATA[15:1], 1'b0};
`ifdef HPI_AUTOINC_EN
      // 16-bit add wraps 16'hFFFE to 0; out-of-range accesses still advance.
      else if ((wr_start && OTG_ADDR == REG_DATA) || (rd_fin && rd_sel == REG_DATA))
        address <= address + 16'd2;
`endif

      // A host write in the same cycle as a local ack wins and is not an
      // overflow, since the previous word is being consumed right now.
      if (wr_start && OTG_ADDR == REG_MBX) begin
        mbx_in_data  <= OTG_DATA;
        mbx_in_valid <= 1'b1;
        if (mbx_in_valid && !mbx_in_ack)
          overflow <= 1'b1;
      end else if (mbx_in_ack) begin
        mbx_in_valid <= 1'b0;
      end

      if (wr_start && OTG_ADDR == REG_STAT && OTG_DATA[2])
        overflow <= 1'b0;

      // A local post wins over a host MAILBOX read ending in the same cycle.
      if (mbx_out_wr) begin
        out_data     <= mbx_out_data;
        mbx_out_full <= 1'b1;
        OTG_INT      <= 1'b1;
      end else if (rd_fin && rd_sel == REG_MBX) begin
        mbx_out_full <= 1'b0;
        OTG_INT      <= 1'b0;
      end

      if (rd_start) begin
        rd_sel   <= reg_sel_e'(OTG_ADDR);
        lat_cnt  <= LAT_INIT;
        rd_state <= RD_WAIT;
        oe       <= 1'b0;
      end else begin
        case (rd_state)
          RD_IDLE: ;
          RD_WAIT: begin
            if (rd_end) begin
              rd_state <= RD_IDLE;
            end else if (lat_cnt == 3'd0) begin
              rd_state <= RD_DRIVE;
              oe       <= 1'b1;
              dout     <= read_word;
            end else begin
              lat_cnt <= lat_cnt - 3'd1;
            end
          end
          RD_DRIVE: begin
            if (rd_end) begin
              rd_state <= RD_IDLE;
              oe       <= 1'b0;
            end
          end
          default: rd_state <= RD_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hpi_responder.sv
// Directed bench for hpi_responder: a vector table of host register
// accesses plus hand-written mailbox, latency and reset sequences.
// The bus is a tri1 net, so a released OTG_DATA reads 16'hFFFF.
module tb_hpi_responder;

  localparam int MEM_WORDS = 1024;
  localparam int RD_LAT    = 1;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

`ifdef HPI_AUTOINC_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif
  localparam logic [15:0] RD1_EXP  = AUTO ? 16'hBEEF : 16'h1234;
  localparam logic [15:0] ADDR_EXP = AUTO ? 16'h0104 : 16'h0100;
  localparam logic [15:0] WRAP_EXP = AUTO ? 16'h0000 : 16'hFFFE;
  localparam logic [15:0] BUS_IDLE = 16'hFFFF;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  OTG_ADDR;
  logic        OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N;
  logic        OTG_INT;
  logic        mbx_in_valid;
  logic [15:0] mbx_in_data;
  logic        mbx_in_ack;
  logic        mbx_out_wr;
  logic [15:0] mbx_out_data;
  logic        mbx_out_full;

  tri1  [15:0] otg_data;
  logic [15:0] host_data;
  logic        host_oe;
  assign otg_data = host_oe ? host_data : 16'hzzzz;

  always #10 Clk = ~Clk;

  hpi_responder #(.MEM_WORDS(MEM_WORDS), .RD_LAT(RD_LAT)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .OTG_DATA     (otg_data),
    .OTG_ADDR     (OTG_ADDR),
    .OTG_CS_N     (OTG_CS_N),
    .OTG_RD_N     (OTG_RD_N),
    .OTG_WR_N     (OTG_WR_N),
    .OTG_RST_N    (OTG_RST_N),
    .OTG_INT      (OTG_INT),
    .mbx_in_valid (mbx_in_valid),
    .mbx_in_data  (mbx_in_data),
    .mbx_in_ack   (mbx_in_ack),
    .mbx_out_wr   (mbx_out_wr),
    .mbx_out_data (mbx_out_data),
    .mbx_out_full (mbx_out_full)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge of Clk.
  task automatic hpi_write(input logic [1:0] a, input logic [15:0] d, input logic ack_now);
    OTG_ADDR   = a;
    host_data  = d;
    host_oe    = 1'b1;
    OTG_CS_N   = 1'b0;
    OTG_WR_N   = 1'b0;
    mbx_in_ack = ack_now;
    @(negedge Clk);
    mbx_in_ack = 1'b0;
    OTG_WR_N   = 1'b1;
    @(negedge Clk);
    OTG_CS_N   = 1'b1;
    host_oe    = 1'b0;
    @(negedge Clk);
  endtask

  // Returns the word on the bus while driven and the bus one cycle after
  // RD_N rises; optionally posts an outbound word on the RD_N rise.
  task automatic hpi_read(input logic [1:0] a, input logic post_wr, input logic [15:0] post_d,
                          output logic [15:0] d, output logic [15:0] after);
    OTG_ADDR = a;
    OTG_CS_N = 1'b0;
    OTG_RD_N = 1'b0;
    repeat (RD_LAT + 1) @(negedge Clk);
    d        = otg_data;
    OTG_RD_N = 1'b1;
    if (post_wr) begin
      mbx_out_wr   = 1'b1;
      mbx_out_data = post_d;
    end
    @(negedge Clk);
    mbx_out_wr = 1'b0;
    after      = otg_data;
    OTG_CS_N   = 1'b1;
  endtask

  typedef struct {
    logic        is_rd;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rdat, rafter;

    vecs[0]  = '{1'b0, A_ADDR, 16'h0100, 16'h0000};
    vecs[1]  = '{1'b0, A_DATA, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1'b0, A_DATA, 16'h1234, 16'h0000};
    vecs[3]  = '{1'b0, A_ADDR, 16'h0100, 16'h0000};
    vecs[4]  = '{1'b1, A_DATA, 16'h0000, RD1_EXP};
    vecs[5]  = '{1'b1, A_DATA, 16'h0000, 16'h1234};
    vecs[6]  = '{1'b1, A_ADDR, 16'h0000, ADDR_EXP};
    vecs[7]  = '{1'b0, A_ADDR, 16'h0203, 16'h0000};
    vecs[8]  = '{1'b1, A_ADDR, 16'h0000, 16'h0202};
    vecs[9]  = '{1'b1, A_MBX,  16'h0000, 16'h0000};
    vecs[10] = '{1'b0, A_ADDR, 16'h07FE, 16'h0000};
    vecs[11] = '{1'b0, A_DATA, 16'h1111, 16'h0000};
    vecs[12] = '{1'b0, A_ADDR, 16'hFFFE, 16'h0000};
    vecs[13] = '{1'b0, A_DATA, 16'h7777, 16'h0000};
    vecs[14] = '{1'b1, A_ADDR, 16'h0000, WRAP_EXP};
    vecs[15] = '{1'b0, A_ADDR, 16'hFFFE, 16'h0000};
    vecs[16] = '{1'b1, A_DATA, 16'h0000, 16'h0000};
    vecs[17] = '{1'b1, A_ADDR, 16'h0000, WRAP_EXP};
    vecs[18] = '{1'b0, A_ADDR, 16'h07FE, 16'h0000};
    vecs[19] = '{1'b1, A_DATA, 16'h0000, 16'h1111};

    Reset        = 1'b1;
    OTG_ADDR     = 2'd0;
    OTG_CS_N     = 1'b1;
    OTG_RD_N     = 1'b1;
    OTG_WR_N     = 1'b1;
    OTG_RST_N    = 1'b1;
    mbx_in_ack   = 1'b0;
    mbx_out_wr   = 1'b0;
    mbx_out_data = 16'h0000;
    host_data    = 16'h0000;
    host_oe      = 1'b0;

    // Reset state
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("reset_int",       {15'b0, OTG_INT},      16'h0000);
    check("reset_in_valid",  {15'b0, mbx_in_valid}, 16'h0000);
    check("reset_out_full",  {15'b0, mbx_out_full}, 16'h0000);
    check("reset_in_data",   mbx_in_data,           16'h0000);
    check("reset_bus_idle",  otg_data,              BUS_IDLE);
    hpi_read(A_STAT, 1'b0, 16'h0000, rdat, rafter);
    check("reset_status", rdat, 16'h0000);
    @(negedge Clk);

    // Register/RAM vector table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_rd) begin
        hpi_read(vecs[i].a, 1'b0, 16'h0000, rdat, rafter);
        check($sformatf("vec%0d_data", i), rdat, vecs[i].exp);
        check($sformatf("vec%0d_release", i), rafter, BUS_IDLE);
        @(negedge Clk);
      end else begin
        hpi_write(vecs[i].a, vecs[i].d, 1'b0);
      end
    end

    // Inbound mailbox, overflow and clear
    hpi_write(A_MBX, 16'h00AA, 1'b0);
    check("mbx_in_valid_1", {15'b0, mbx_in_valid}, 16'h0001);
    check("mbx_in_data_1",  mbx_in_data,           16'h00AA);
    hpi_write(A_MBX, 16'h00BB, 1'b0);
    check("mbx_in_data_2",  mbx_in_data,           16'h00BB);
    hpi_read(A_STAT, 1'b0, 16'h0000, rdat, rafter);
    check("status_overflow", rdat, 16'h0006);
    @(negedge Clk);
    hpi_write(A_STAT, 16'h0004, 1'b0);
    hpi_read(A_STAT, 1'b0, 16'h0000, rdat, rafter);
    check("status_w1c", rdat, 16'h0002);
    @(negedge Clk);
    mbx_in_ack = 1'b1;
    @(negedge Clk);
    mbx_in_ack = 1'b0;
    check("mbx_ack_clears", {15'b0, mbx_in_valid}, 16'h0000);
    hpi_read(A_STAT, 1'b0, 16'h0000, rdat, rafter);
    check("status_clear", rdat, 16'h0000);
    @(negedge Clk);

    // Host write and local ack in the same cycle
    hpi_write(A_MBX, 16'h00CC, 1'b0);
    hpi_write(A_MBX, 16'h00DD, 1'b1);
    check("mbx_ack_write_data", mbx_in_data, 16'h00DD);
    hpi_read(A_STAT, 1'b0, 16'h0000, rdat, rafter);
    check("status_ack_write", rdat, 16'h0002);
    @(negedge Clk);
    mbx_in_ack = 1'b1;
    @(negedge Clk);
    mbx_in_ack = 1'b0;

    // Outbound mailbox and interrupt
    mbx_out_data = 16'h5A5A;
    mbx_out_wr   = 1'b1;
    @(negedge Clk);
    mbx_out_wr   = 1'b0;
    check("int_after_post", {15'b0, OTG_INT},      16'h0001);
    check("out_full_post",  {15'b0, mbx_out_full}, 16'h0001);
    hpi_read(A_STAT, 1'b0, 16'h0000, rdat, rafter);
    check("status_out_full", rdat, 16'h0001);
    @(negedge Clk);
    hpi_read(A_MBX, 1'b0, 16'h0000, rdat, rafter);
    check("mbx_out_read", rdat, 16'h5A5A);
    check("int_after_read", {15'b0, OTG_INT},      16'h0000);
    check("out_full_read",  {15'b0, mbx_out_full}, 16'h0000);
    @(negedge Clk);

    // Local post coinciding with the RD_N rise of a MAILBOX read
    mbx_out_data = 16'h5A5A;
    mbx_out_wr   = 1'b1;
    @(negedge Clk);
    mbx_out_wr   = 1'b0;
    hpi_read(A_MBX, 1'b1, 16'h1357, rdat, rafter);
    check("mbx_out_read_2",  rdat, 16'h5A5A);
    check("int_kept_by_wr",  {15'b0, OTG_INT},      16'h0001);
    check("full_kept_by_wr", {15'b0, mbx_out_full}, 16'h0001);
    @(negedge Clk);
    hpi_read(A_MBX, 1'b0, 16'h0000, rdat, rafter);
    check("mbx_out_new_data", rdat, 16'h1357);
    check("int_after_read_2", {15'b0, OTG_INT}, 16'h0000);
    @(negedge Clk);

    // HPI reset in the middle of a DATA read
    hpi_write(A_ADDR, 16'h0100, 1'b0);
    OTG_ADDR = A_DATA;
    OTG_CS_N = 1'b0;
    OTG_RD_N = 1'b0;
    repeat (RD_LAT + 1) @(negedge Clk);
    check("rst_read_data", otg_data, RD1_EXP);
    OTG_RST_N = 1'b0;
    @(negedge Clk);
    check("rst_bus_released", otg_data, BUS_IDLE);
    OTG_RST_N = 1'b1;
    OTG_RD_N  = 1'b1;
    @(negedge Clk);
    OTG_CS_N  = 1'b1;
    @(negedge Clk);
    hpi_read(A_ADDR, 1'b0, 16'h0000, rdat, rafter);
    check("rst_addr_zero", rdat, 16'h0000);
    @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
